// File: rtl/jtag_host.sv
// Bit-level JTAG host: shifts 1..32 TMS/TDI bits LSB first at a TCK derived
// from clk, captures TDO on each falling TCK edge and returns it as a response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command; TCK low, TMS/TDI hold last bit
// LOW     | TCK low; TMS/TDI for the current bit are on the pins
// HIGH    | TCK high; TDO captured when this phase ends (TCK falls)
module jtag_host #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_tms,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  output logic [31:0] rsp_tdo,
  output logic        busy,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_idx;
  logic [4:0]  r_len;
  logic [31:0] r_tms;
  logic [31:0] r_tdi;
  logic [31:0] r_cap;
  logic        r_tck;
  logic        r_tms_o;
  logic        r_tdi_o;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_tdo;
  logic        r_ready;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [4:0]  w_idx_nxt;
  logic [4:0]  w_len_nxt;
  logic [31:0] w_tms_nxt;
  logic [31:0] w_tdi_nxt;
  logic [31:0] w_cap_nxt;
  logic        w_tck_nxt;
  logic        w_tms_o_nxt;
  logic        w_tdi_o_nxt;
  logic        w_rsp_valid_nxt;
  logic [31:0] w_rsp_tdo_nxt;

  logic        w_accept;
  logic        w_half_done;
  logic        w_last_bit;
  logic [4:0]  w_idx_inc;
  logic [31:0] w_cap_upd;

  assign w_accept    = cmd_valid & r_ready;
  assign w_half_done = (r_cnt == DIV_M1);
  assign w_last_bit  = (r_idx == r_len);
  assign w_idx_inc   = (r_idx == 5'd31) ? r_idx : r_idx + 5'd1;
  // capture includes the bit sampled on this falling edge
  assign w_cap_upd   = r_cap | (32'(jtag_tdo) << r_idx);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_len_nxt       = r_len;
    w_tms_nxt       = r_tms;
    w_tdi_nxt       = r_tdi;
    w_cap_nxt       = r_cap;
    w_tck_nxt       = r_tck;
    w_tms_o_nxt     = r_tms_o;
    w_tdi_o_nxt     = r_tdi_o;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_tdo_nxt   = r_rsp_tdo;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = 8'd0;
          w_idx_nxt   = 5'd0;
          w_len_nxt   = cmd_len;
          w_tms_nxt   = cmd_tms;
          w_tdi_nxt   = cmd_tdi;
          w_cap_nxt   = 32'd0;
          w_tms_o_nxt = cmd_tms[0];
          w_tdi_o_nxt = cmd_tdi[0];
        end
      end
      ST_LOW: begin
        if (w_half_done) begin
          w_state_nxt = ST_HIGH;
          w_tck_nxt   = 1'b1;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_HIGH: begin
        if (w_half_done) begin
          w_tck_nxt = 1'b0;
          w_cnt_nxt = 8'd0;
          w_cap_nxt = w_cap_upd;
          if (w_last_bit) begin
            w_state_nxt     = ST_IDLE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_tdo_nxt   = w_cap_upd;
          end else begin
            w_state_nxt = ST_LOW;
            w_idx_nxt   = w_idx_inc;
            w_tms_o_nxt = r_tms[w_idx_inc];
            w_tdi_o_nxt = r_tdi[w_idx_inc];
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tck_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_idx       <= 5'd0;
      r_len       <= 5'd0;
      r_tms       <= 32'd0;
      r_tdi       <= 32'd0;
      r_cap       <= 32'd0;
      r_tck       <= 1'b0;
      r_tms_o     <= 1'b1;
      r_tdi_o     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tdo   <= 32'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_len       <= w_len_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi       <= w_tdi_nxt;
      r_cap       <= w_cap_nxt;
      r_tck       <= w_tck_nxt;
      r_tms_o     <= w_tms_o_nxt;
      r_tdi_o     <= w_tdi_o_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_tdo   <= w_rsp_tdo_nxt;
      r_ready     <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_tdo   = r_rsp_tdo;
  assign busy      = r_busy;
  assign jtag_tck  = r_tck;
  assign jtag_tms  = r_tms_o;
  assign jtag_tdi  = r_tdi_o;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host: three instances at CLK_DIV = 2, 1 and 3,
// a table of commands plus hand sequences for reset, back-to-back and edge timing.
module tb_jtag_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n, cmd_valid, cmd_ready, rsp_valid, busy;
  logic [2:0]       jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
  logic [2:0][4:0]  cmd_len;
  logic [2:0][31:0] cmd_tms, cmd_tdi, rsp_tdo;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    jtag_host #(.CLK_DIV(DIV)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_len   (cmd_len[g]),
      .cmd_tms   (cmd_tms[g]),
      .cmd_tdi   (cmd_tdi[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_tdo   (rsp_tdo[g]),
      .busy      (busy[g]),
      .jtag_tck  (jtag_tck[g]),
      .jtag_tms  (jtag_tms[g]),
      .jtag_tdi  (jtag_tdi[g]),
      .jtag_tdo  (jtag_tdo[g])
    );
  end

  typedef struct {
    bit [1:0]    k;
    logic [4:0]  len;
    logic [31:0] tms, tdi, tdo;
    logic [31:0] exp_rsp, exp_tms, exp_tdi;
    int          exp_lat, exp_pulses;
  } vec_t;

  vec_t vecs[6];
  int n_vec = 0;
  int n_err = 0;
  logic [255:0] tr_tck, tr_tms, tr_tdi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input bit [1:0] k, input string tag);
    check({tag, "_tck"},   32'(jtag_tck[k]),  32'd0);
    check({tag, "_tms"},   32'(jtag_tms[k]),  32'd1);
    check({tag, "_tdi"},   32'(jtag_tdi[k]),  32'd0);
    check({tag, "_ready"}, 32'(cmd_ready[k]), 32'd0);
    check({tag, "_busy"},  32'(busy[k]),      32'd0);
    check({tag, "_rspv"},  32'(rsp_valid[k]), 32'd0);
    check({tag, "_rsp"},   rsp_tdo[k],        32'd0);
  endtask

  // Issue one command, follow it to rsp_valid, feed TDO from tdo_word and record pins.
  task automatic run_cmd(input bit [1:0] k, input logic [4:0] len,
                         input logic [31:0] tms, input logic [31:0] tdi, input logic [31:0] tdo_word,
                         output logic [31:0] rsp, output int lat,
                         output logic [31:0] tms_seen, output logic [31:0] tdi_seen, output int pulses);
    logic [31:0] w;
    logic        prev;
    int          guard;
    rsp = 32'd0; lat = 0; tms_seen = 32'd0; tdi_seen = 32'd0; pulses = 0; guard = 0;
    while (!cmd_ready[k] && guard < 50) begin
      tick();
      guard++;
    end
    if (!cmd_ready[k]) check("ready_wait", 32'(cmd_ready[k]), 32'd1);
    w = tdo_word;
    jtag_tdo[k]  = w[0];
    cmd_len[k]   = len;
    cmd_tms[k]   = tms;
    cmd_tdi[k]   = tdi;
    cmd_valid[k] = 1'b1;
    tick();
    cmd_valid[k] = 1'b0;
    cmd_len[k]   = 5'($urandom);
    cmd_tms[k]   = $urandom;
    cmd_tdi[k]   = $urandom;
    tr_tck[0] = jtag_tck[k];
    tr_tms[0] = jtag_tms[k];
    tr_tdi[0] = jtag_tdi[k];
    prev = jtag_tck[k];
    while (lat < 300) begin
      tick();
      lat++;
      if (lat < 256) begin
        tr_tck[8'(lat)] = jtag_tck[k];
        tr_tms[8'(lat)] = jtag_tms[k];
        tr_tdi[8'(lat)] = jtag_tdi[k];
      end
      if (rsp_valid[k]) begin
        rsp = rsp_tdo[k];
        break;
      end
      if (!prev && jtag_tck[k]) begin
        if (pulses < 32) begin
          tms_seen[pulses[4:0]] = jtag_tms[k];
          tdi_seen[pulses[4:0]] = jtag_tdi[k];
        end
        pulses++;
      end
      if (prev && !jtag_tck[k]) begin
        w = w >> 1;
        jtag_tdo[k] = w[0];
      end
      prev = jtag_tck[k];
    end
    if (!rsp_valid[k]) check("rsp_timeout", 32'(rsp_valid[k]), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rsp, tms_seen, tdi_seen;
    int          lat, pulses, c, r_at, rise_at, rv_cnt;
    logic        prev, tms_or, tms_at_rise, ok;
    vec_t        v;

    vecs[0] = '{k: 2'd0, len: 5'd4,  tms: 32'h0000_000F, tdi: 32'h0000_0016, tdo: 32'h0,
                exp_rsp: 32'h0, exp_tms: 32'h0000_000F, exp_tdi: 32'h0000_0016, exp_lat: 20, exp_pulses: 5};
    vecs[1] = '{k: 2'd0, len: 5'd31, tms: 32'h8000_0000, tdi: 32'h0, tdo: 32'h1234_5A5B,
                exp_rsp: 32'h1234_5A5B, exp_tms: 32'h8000_0000, exp_tdi: 32'h0, exp_lat: 128, exp_pulses: 32};
    vecs[2] = '{k: 2'd1, len: 5'd0,  tms: 32'h0000_0002, tdi: 32'hFFFF_FFFF, tdo: 32'h1,
                exp_rsp: 32'h1, exp_tms: 32'h0, exp_tdi: 32'h1, exp_lat: 2, exp_pulses: 1};
    vecs[3] = '{k: 2'd1, len: 5'd31, tms: 32'hA5A5_0F0F, tdi: 32'h3C3C_C3C3, tdo: 32'hDEAD_BEEF,
                exp_rsp: 32'hDEAD_BEEF, exp_tms: 32'hA5A5_0F0F, exp_tdi: 32'h3C3C_C3C3, exp_lat: 64, exp_pulses: 32};
    vecs[4] = '{k: 2'd0, len: 5'd7,  tms: 32'h0000_005A, tdi: 32'hFFFF_0099, tdo: 32'hFFFF_FFFF,
                exp_rsp: 32'h0000_00FF, exp_tms: 32'h0000_005A, exp_tdi: 32'h0000_0099, exp_lat: 32, exp_pulses: 8};
    vecs[5] = '{k: 2'd2, len: 5'd2,  tms: 32'h0000_0005, tdi: 32'h0000_0003, tdo: 32'h0000_0006,
                exp_rsp: 32'h6, exp_tms: 32'h5, exp_tdi: 32'h3, exp_lat: 18, exp_pulses: 3};

    rst_n = 3'b000; cmd_valid = 3'b000; jtag_tdo = 3'b000;
    cmd_len = '0; cmd_tms = '0; cmd_tdi = '0;

    // reset values and release
    repeat (3) tick();
    for (int k = 0; k < 3; k++) check_reset_vals(2'(k), $sformatf("rst%0d", k));
    rst_n = 3'b111;
    tick();
    rv_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rel%0d_ready", k), 32'(cmd_ready[k]), 32'd1);
      check($sformatf("rel%0d_tms", k),   32'(jtag_tms[k]),  32'd1);
    end
    repeat (5) begin
      tick();
      if (rsp_valid != 3'b000) rv_cnt++;
    end
    check("idle_no_rsp", 32'(rv_cnt), 32'd0);

    // table of commands
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      run_cmd(v.k, v.len, v.tms, v.tdi, v.tdo, rsp, lat, tms_seen, tdi_seen, pulses);
      check($sformatf("v%0d_rsp", i),    rsp,          v.exp_rsp);
      check($sformatf("v%0d_lat", i),    32'(lat),     32'(v.exp_lat));
      check($sformatf("v%0d_pulses", i), 32'(pulses),  32'(v.exp_pulses));
      check($sformatf("v%0d_tms", i),    tms_seen,     v.exp_tms);
      check($sformatf("v%0d_tdi", i),    tdi_seen,     v.exp_tdi);
      tick();
      check($sformatf("v%0d_pulse1", i), 32'(rsp_valid[v.k]), 32'd0);
      check($sformatf("v%0d_busy", i),   32'(busy[v.k]),      32'd0);
      check($sformatf("v%0d_tckidle", i), 32'(jtag_tck[v.k]), 32'd0);
      check($sformatf("v%0d_tmshold", i), 32'(jtag_tms[v.k]), 32'(v.tms[v.len]));
      check($sformatf("v%0d_tdihold", i), 32'(jtag_tdi[v.k]), 32'(v.tdi[v.len]));
      check($sformatf("v%0d_rsphold", i), rsp_tdo[v.k],       v.exp_rsp);
    end

    // reset in the middle of a 32-bit command on the CLK_DIV=2 engine
    cmd_len[0] = 5'd31; cmd_tms[0] = 32'h0; cmd_tdi[0] = 32'hFFFF_FFFF; cmd_valid[0] = 1'b1;
    tick();
    cmd_valid[0] = 1'b0;
    repeat (10) tick();
    check("mid_tck", 32'(jtag_tck[0]), 32'd1);
    check("mid_tms", 32'(jtag_tms[0]), 32'd0);
    check("mid_tdi", 32'(jtag_tdi[0]), 32'd1);
    check("mid_busy", 32'(busy[0]), 32'd1);
    rst_n[0] = 1'b0;
    tick();
    check_reset_vals(2'd0, "abort");
    tick();
    rst_n[0] = 1'b1;
    tick();
    check("abort_ready", 32'(cmd_ready[0]), 32'd1);
    rv_cnt = 0;
    repeat (140) begin
      tick();
      if (rsp_valid[0]) rv_cnt++;
    end
    check("abort_no_rsp", 32'(rv_cnt), 32'd0);

    // busy rejection, then back-to-back acceptance in the rsp_valid cycle
    jtag_tdo[0] = 1'b0;
    cmd_len[0] = 5'd3; cmd_tms[0] = 32'h0; cmd_tdi[0] = 32'hF; cmd_valid[0] = 1'b1;
    tick();
    cmd_len[0] = 5'd0; cmd_tms[0] = 32'h1; cmd_tdi[0] = 32'h0;
    c = 0; r_at = -1; pulses = 0; tms_or = 1'b0; prev = jtag_tck[0];
    while (c < 60 && r_at < 0) begin
      tick();
      c++;
      if (c == 5) begin
        check("bb_busy", 32'(busy[0]), 32'd1);
        check("bb_notready", 32'(cmd_ready[0]), 32'd0);
      end
      if (!prev && jtag_tck[0]) begin
        pulses++;
        tms_or = tms_or | jtag_tms[0];
      end
      if (rsp_valid[0]) r_at = c;
      prev = jtag_tck[0];
    end
    check("bb_a_rsp_at", 32'(r_at), 32'd16);
    check("bb_a_pulses", 32'(pulses), 32'd4);
    check("bb_a_tms", 32'(tms_or), 32'd0);
    check("bb_a_rsp", rsp_tdo[0], 32'h0);
    jtag_tdo[0] = 1'b1;
    rise_at = -1; tms_at_rise = 1'b0;
    while (c < 80 && rise_at < 0) begin
      tick();
      c++;
      if (c == r_at + 1) cmd_valid[0] = 1'b0;
      if (jtag_tck[0]) begin
        rise_at = c;
        tms_at_rise = jtag_tms[0];
      end
    end
    check("bb_gap", 32'(rise_at - r_at), 32'd3);
    check("bb_b_tms", 32'(tms_at_rise), 32'd1);
    while (c < 100 && !rsp_valid[0]) begin
      tick();
      c++;
    end
    check("bb_b_rsp_at", 32'(c - r_at), 32'd5);
    check("bb_b_rsp", rsp_tdo[0], 32'h1);

    // edge alignment at CLK_DIV=3
    run_cmd(2'd2, 5'd3, 32'b1010, 32'b0110, 32'h0, rsp, lat, tms_seen, tdi_seen, pulses);
    check("al_lat", 32'(lat), 32'd24);
    for (int i = 0; i < 4; i++) begin
      int r;
      r = 6 * i + 3;
      ok = !tr_tck[8'(r - 1)] && tr_tck[8'(r)] && tr_tck[8'(r + 1)] && tr_tck[8'(r + 2)]
           && !tr_tck[8'(r + 3)];
      ok = ok && (tr_tms[8'(r)] == ((4'b1010 >> i) & 4'b1) != 0)
              && (tr_tdi[8'(r)] == ((4'b0110 >> i) & 4'b1) != 0);
      for (int j = r - 3; j <= r + 2; j++)
        ok = ok && (tr_tms[8'(j)] == tr_tms[8'(r)]) && (tr_tdi[8'(j)] == tr_tdi[8'(r)]);
      check($sformatf("al_rise%0d", i), 32'(ok), 32'd1);
    end

    // TDO sampled at the falling edge, not the rising one
    for (int t = 0; t < 2; t++) begin
      jtag_tdo[2] = (t == 1);
      cmd_len[2] = 5'd0; cmd_tms[2] = 32'h1; cmd_tdi[2] = 32'h0; cmd_valid[2] = 1'b1;
      tick();
      cmd_valid[2] = 1'b0;
      c = 0;
      while (c < 20 && !rsp_valid[2]) begin
        tick();
        c++;
        if (t == 0 && c == 2) jtag_tdo[2] = 1'b1;
        if (t == 1 && c == 5) jtag_tdo[2] = 1'b0;
      end
      check($sformatf("fall%0d_at", t), 32'(c), 32'd6);
      check($sformatf("fall%0d_tdo", t), rsp_tdo[2], (t == 0) ? 32'h1 : 32'h0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
